multiplier_seq: RTL

MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

---
 rtl/multiplier_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/multiplier_seq.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes on accept; the sign is reapplied when the result is loaded.
module multiplier_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic                 rx_signed,
    input  logic [WIDTH-1:0]     rx_op0,
    input  logic [WIDTH-1:0]     rx_op1,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [2*WIDTH-1:0]   tx_result,
    output logic                 tx_busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   mcand, acc, result, partial, sum;
    logic [WIDTH-1:0]     mplier, mag0, mag1;
    logic [CW-1:0]        cnt;
    logic                 neg, eff_signed, accept, last;

    always_comb begin
        eff_signed = rx_signed & SIGNED_EN;
        // most-negative input negates to itself, which reads correctly as an unsigned magnitude
        mag0       = (eff_signed && rx_op0[WIDTH-1]) ? -rx_op0 : rx_op0;
        mag1       = (eff_signed && rx_op1[WIDTH-1]) ? -rx_op1 : rx_op1;
        partial    = mplier[0] ? mcand : '0;
        sum        = acc + partial;
        last       = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_busy    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                tx_busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag0};
            mplier <= mag1;
            acc    <= '0;
            cnt    <= '0;
            neg    <= eff_signed & (rx_op0[WIDTH-1] ^ rx_op1[WIDTH-1]);
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result <= neg ? -sum : sum;
            end
        end
    end

    assign tx_result = result;

endmodule
